// File: rtl/dflipflop_pipe.sv
// dflipflop_pipe: WIDTH-bit, DEPTH-stage stallable delay line with per-stage
// valid bits, a valid-only flush and a registered occupancy count / full flag.
// Each stage is a small register cell; the top chains them and tracks
// occupancy alongside so fill_cnt/full change on the same edge as the stages.

module dflipflop_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] d_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  // One stage: reset > flush (valid only, data kept) > advance > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else if (flush) begin
      vld_q  <= 1'b0;
    end else if (en) begin
      data_q <= d_i;
      vld_q  <= vld_i;
    end
  end

  assign d_o   = data_q;
  assign vld_o = vld_q;
endmodule

module dflipflop_pipe #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter bit               ZERO_INVALID = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_vld,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_vld,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       full
);
  localparam int CW = $clog2(DEPTH+1);

  // chain_d[i] feeds stage i; chain_d[DEPTH] is the last stage's output.
  logic [DEPTH:0][WIDTH-1:0] chain_d;
  logic [DEPTH:0]            chain_v;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  // Bubbles can be scrubbed to RESET_VAL so an X on din never enters the line.
  assign chain_d[0] = (ZERO_INVALID && !din_vld) ? RESET_VAL : din;
  assign chain_v[0] = din_vld;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      dflipflop_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .en    (en),
        .d_i   (chain_d[g]),
        .vld_i (chain_v[g]),
        .d_o   (chain_d[g+1]),
        .vld_o (chain_v[g+1])
      );
    end
  endgenerate

  // Occupancy on an advance: one item may enter and the oldest leaves, so the
  // count moves by din_vld minus the outgoing valid; it cannot leave 0..DEPTH.
  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (en) begin
      cnt_d  = cnt_q + CW'(din_vld) - CW'(chain_v[DEPTH]);
      full_d = (cnt_d == CW'(DEPTH));
    end
  end

  // Occupancy registers share the stages' reset/flush/enable priority.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign dout     = chain_d[DEPTH];
  assign dout_vld = chain_v[DEPTH];
  assign fill_cnt = cnt_q;
  assign full     = full_q;
endmodule

// File: tb/tb_dflipflop_pipe.sv
// Bench for dflipflop_pipe: two instances (plain, and ZERO_INVALID with a
// non-zero reset value) share stimulus. A queue-based model of the line's
// contents predicts every output after every edge; table rows and hand
// sequences additionally pin explicit expected values.

module tb_dflipflop_pipe;
  localparam int         W   = 8;
  localparam int         D   = 4;
  localparam logic [7:0] RV1 = 8'h5A;

  logic       clk = 1'b0;
  logic       reset, en, flush, din_vld;
  logic [7:0] din;
  logic [7:0] dout0, dout1;
  logic       dvld0, dvld1, full0, full1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dflipflop_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00), .ZERO_INVALID(1'b0)) u0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
    .dout(dout0), .dout_vld(dvld0), .fill_cnt(cnt0), .full(full0));

  dflipflop_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV1), .ZERO_INVALID(1'b1)) u1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
    .dout(dout1), .dout_vld(dvld1), .fill_cnt(cnt1), .full(full1));

  // Model: the line as a queue, front = newest, back = what dout shows.
  logic [7:0] m0d[$], m1d[$];
  bit         m0v[$], m1v[$];

  function automatic int pop_cnt(input bit v[$]);
    int n = 0;
    foreach (v[i]) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_step(input logic r, e, f, input logic [7:0] d, input logic dv);
    if (r) begin
      m0d = {}; m0v = {}; m1d = {}; m1v = {};
      for (int i = 0; i < D; i++) begin
        m0d.push_back(8'h00); m0v.push_back(1'b0);
        m1d.push_back(RV1);   m1v.push_back(1'b0);
      end
    end else if (f) begin
      foreach (m0v[i]) m0v[i] = 1'b0;
      foreach (m1v[i]) m1v[i] = 1'b0;
    end else if (e) begin
      m0d.push_front(d);               m0v.push_front(dv);
      m1d.push_front(dv ? d : RV1);    m1v.push_front(dv);
      void'(m0d.pop_back()); void'(m0v.pop_back());
      void'(m1d.pop_back()); void'(m1v.pop_back());
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    int n0, n1;
    n0 = pop_cnt(m0v);
    n1 = pop_cnt(m1v);
    chk("m0.dout",  32'(dout0), 32'(m0d[D-1]));
    chk("m0.vld",   32'(dvld0), 32'(m0v[D-1]));
    chk("m0.cnt",   32'(cnt0),  32'(n0));
    chk("m0.full",  32'(full0), 32'(n0 == D));
    chk("m1.dout",  32'(dout1), 32'(m1d[D-1]));
    chk("m1.vld",   32'(dvld1), 32'(m1v[D-1]));
    chk("m1.cnt",   32'(cnt1),  32'(n1));
    chk("m1.full",  32'(full1), 32'(n1 == D));
    chk("m1.known", 32'($isunknown(dout1)), 32'(0));
  endtask

  // Apply one cycle, advance the model on the same edge, compare 1 time unit later.
  task automatic step(input logic r, e, f, input logic [7:0] d, input logic dv);
    reset = r; en = e; flush = f; din = d; din_vld = dv;
    @(posedge clk);
    model_step(r, e, f, d, dv);
    #1;
    chk_model();
  endtask

  task automatic chk_exp(input string name, input logic [7:0] d, input logic v,
                         input logic [2:0] c, input logic fl);
    chk({name, ".dout"}, 32'(dout0), 32'(d));
    chk({name, ".vld"},  32'(dvld0), 32'(v));
    chk({name, ".cnt"},  32'(cnt0),  32'(c));
    chk({name, ".full"}, 32'(full0), 32'(fl));
  endtask

  typedef struct {
    logic       r, e, f;
    logic [7:0] d;
    logic       dv;
    logic [7:0] xd;
    logic       xv;
    logic [2:0] xc;
    logic       xf;
  } vec_t;

  vec_t tbl[$];

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].d, tbl[i].dv);
      chk_exp($sformatf("%s.row%0d", tag, i), tbl[i].xd, tbl[i].xv, tbl[i].xc, tbl[i].xf);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       r, e, f, dv;
    reset = 1'b1; en = 1'b0; flush = 1'b0; din = '0; din_vld = 1'b0;

    // Reset rows (inputs active, must be ignored), then fill and drain.
    tbl.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 8'h11, 1'b1, 3'd4, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 8'h22, 1'b1, 3'd4, 1'b1});
    run_table("fill");

    // Stall at fill_cnt=3: nothing moves while din toggles; resume in order.
    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h31, 1);
    step(0, 1, 0, 8'h32, 1);
    step(0, 1, 0, 8'h33, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, (i[0] ? 8'hF0 : 8'h0F), 1'(i));
      chk_exp($sformatf("stall%0d", i), 8'h00, 1'b0, 3'd3, 1'b0);
    end
    step(0, 1, 0, 8'h34, 1); chk_exp("resume0", 8'h31, 1'b1, 3'd4, 1'b1);
    step(0, 1, 0, 8'h00, 0); chk_exp("resume1", 8'h32, 1'b1, 3'd3, 1'b0);
    step(0, 1, 0, 8'h00, 0); chk_exp("resume2", 8'h33, 1'b1, 3'd2, 1'b0);
    step(0, 1, 0, 8'h00, 0); chk_exp("resume3", 8'h34, 1'b1, 3'd1, 1'b0);

    // Flush beats enable: valids clear, data stays, offered item dropped.
    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h11, 1);
    step(0, 1, 0, 8'h22, 1);
    step(0, 1, 0, 8'h33, 1);
    step(0, 1, 0, 8'h44, 1);
    chk_exp("preflush", 8'h11, 1'b1, 3'd4, 1'b1);
    step(0, 1, 1, 8'h99, 1);
    chk_exp("flush", 8'h11, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 8'h00, 0);
      chk($sformatf("noghost%0d", i), 32'(dvld0), 32'(0));
    end

    // Reset mid-operation (fill_cnt=2), then the fill/drain table again.
    step(0, 1, 0, 8'h61, 1);
    step(0, 1, 0, 8'h62, 1);
    chk("mid.cnt", 32'(cnt0), 32'(2));
    run_table("refill");

    // Bubbles: alternate valid/invalid; u1 shows RESET_VAL on bubble slots.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'hA0 + 8'(i), 1'(~i[0]));
      if (i >= 3) begin
        chk($sformatf("bub%0d.vld", i), 32'(dvld0), 32'(i[0]));
        chk($sformatf("bub%0d.cnt", i), 32'(cnt0), 32'(2));
        chk($sformatf("bub%0d.d0", i), 32'(dout0), 32'(8'hA0 + 8'(i - 3)));
        chk($sformatf("bub%0d.d1", i), 32'(dout1), 32'(i[0] ? 8'hA0 + 8'(i - 3) : RV1));
      end
    end

    // Random traffic against the model; unknown din on some bubbles.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) < 2);
      f  = ($urandom_range(99) < 5);
      e  = ($urandom_range(99) < 70);
      dv = ($urandom_range(99) < 60);
      d  = 8'($urandom);
      if (!dv && $urandom_range(3) == 0) d = 'x;
      step(r, e, f, d, dv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
